// File: rtl/colisao_bola_if.sv
// -----------------------------------------------------------------------------
// colisao_bola_if
// Signal bundle between the game logic and the ball/target collision checker.
//   pausa            : game paused, no new evaluation starts
//   amostrar         : one-cycle evaluation request (frame tick)
//   bola_x/y/raio    : ball centre and radius, unsigned pixels
//   alvo_x/y/raio    : target centre and radius, unsigned pixels
//   alvo_ativo       : target alive; low forces a miss
//   atingiu          : registered one-cycle hit pulse
//   ocupado          : evaluation in flight
//   contagem_acertos : saturating count of hit pulses since reset
// master = requester side, slave = collision checker.
// -----------------------------------------------------------------------------
interface colisao_bola_if;
   logic       pausa;
   logic       amostrar;
   logic [9:0] bola_x;
   logic [9:0] bola_y;
   logic [9:0] bola_raio;
   logic [9:0] alvo_x;
   logic [9:0] alvo_y;
   logic [9:0] alvo_raio;
   logic       alvo_ativo;
   logic       atingiu;
   logic       ocupado;
   logic [7:0] contagem_acertos;

   modport master (
      output pausa, amostrar, bola_x, bola_y, bola_raio,
             alvo_x, alvo_y, alvo_raio, alvo_ativo,
      input  atingiu, ocupado, contagem_acertos
   );

   modport slave (
      input  pausa, amostrar, bola_x, bola_y, bola_raio,
             alvo_x, alvo_y, alvo_raio, alvo_ativo,
      output atingiu, ocupado, contagem_acertos
   );
endinterface

// File: rtl/colisao_bola.sv
// -----------------------------------------------------------------------------
// colisao_bola
// Circle-vs-circle collision checker. A request captures ball and target
// geometry, then three pipelined steps compute |dx|,|dy| and the radius sum,
// their squares, and finally compare d^2 <= (r1+r2)^2. A hit is reported as a
// one-cycle pulse, after which CARENCIA further evaluations are suppressed.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-low
//   bus      : colisao_bola_if.slave (request, geometry, hit/busy/count)
// -----------------------------------------------------------------------------
module colisao_bola #(
   parameter int unsigned CARENCIA = 4   // suppressed evaluations after a hit, 0..15
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   colisao_bola_if.slave  bus
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DIF     = 2'd1,
      QUAD    = 2'd2,
      COMPARA = 2'd3
   } estado_t;

   localparam logic [3:0] CARENCIA_4B = 4'(CARENCIA);

   estado_t     state_q, state_d;

   // captured request
   logic [9:0]  bx_q, by_q, br_q, ax_q, ay_q, ar_q;
   logic [9:0]  bx_d, by_d, br_d, ax_d, ay_d, ar_d;
   logic        ativo_q, ativo_d;

   // pipeline registers
   logic [9:0]  dx_q, dx_d, dy_q, dy_d;
   logic [10:0] soma_q, soma_d;
   logic [20:0] d2_q, d2_d;      // max 2*1023^2 = 2093058 fits 21 bits
   logic [21:0] r2_q, r2_d;      // max 2046^2   = 4186116 fits 22 bits

   // outputs and cooldown
   logic        atingiu_q, atingiu_d;
   logic        ocupado_q, ocupado_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  cd_q, cd_d;
   logic        bruto;

   // NOTE: every always_comb target gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      bx_d      = bx_q;
      by_d      = by_q;
      br_d      = br_q;
      ax_d      = ax_q;
      ay_d      = ay_q;
      ar_d      = ar_q;
      ativo_d   = ativo_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      soma_d    = soma_q;
      d2_d      = d2_q;
      r2_d      = r2_q;
      atingiu_d = 1'b0;
      cd_d      = cd_q;
      cnt_d     = cnt_q;
      bruto     = 1'b0;

      unique case (state_q)
         OCIOSO: begin
            if (bus.amostrar && !bus.pausa) begin
               bx_d    = bus.bola_x;
               by_d    = bus.bola_y;
               br_d    = bus.bola_raio;
               ax_d    = bus.alvo_x;
               ay_d    = bus.alvo_y;
               ar_d    = bus.alvo_raio;
               ativo_d = bus.alvo_ativo;
               state_d = DIF;
            end
         end
         DIF: begin
            dx_d    = (bx_q >= ax_q) ? (bx_q - ax_q) : (ax_q - bx_q);
            dy_d    = (by_q >= ay_q) ? (by_q - ay_q) : (ay_q - by_q);
            soma_d  = {1'b0, br_q} + {1'b0, ar_q};
            state_d = QUAD;
         end
         QUAD: begin
            d2_d    = (21'(dx_q) * 21'(dx_q)) + (21'(dy_q) * 21'(dy_q));
            r2_d    = 22'(soma_q) * 22'(soma_q);
            state_d = COMPARA;
         end
         COMPARA: begin
            bruto = ativo_q && ({1'b0, d2_q} <= r2_q);
            // A hit is only reported once the cooldown has drained; any
            // evaluation (hit or miss) spends one unit of cooldown.
            if (cd_q == 4'd0 && bruto) begin
               atingiu_d = 1'b1;
               cd_d      = CARENCIA_4B;
            end else if (cd_q != 4'd0) begin
               cd_d      = cd_q - 4'd1;
            end
            state_d = OCIOSO;
         end
         default: state_d = OCIOSO;
      endcase

      if (atingiu_d && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;

      ocupado_d = (state_d != OCIOSO);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q   <= OCIOSO;
         bx_q      <= '0;
         by_q      <= '0;
         br_q      <= '0;
         ax_q      <= '0;
         ay_q      <= '0;
         ar_q      <= '0;
         ativo_q   <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         soma_q    <= '0;
         d2_q      <= '0;
         r2_q      <= '0;
         atingiu_q <= 1'b0;
         ocupado_q <= 1'b0;
         cnt_q     <= '0;
         cd_q      <= '0;
      end else begin
         state_q   <= state_d;
         bx_q      <= bx_d;
         by_q      <= by_d;
         br_q      <= br_d;
         ax_q      <= ax_d;
         ay_q      <= ay_d;
         ar_q      <= ar_d;
         ativo_q   <= ativo_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         soma_q    <= soma_d;
         d2_q      <= d2_d;
         r2_q      <= r2_d;
         atingiu_q <= atingiu_d;
         ocupado_q <= ocupado_d;
         cnt_q     <= cnt_d;
         cd_q      <= cd_d;
      end
   end

   assign bus.atingiu          = atingiu_q;
   assign bus.ocupado          = ocupado_q;
   assign bus.contagem_acertos = cnt_q;

endmodule

// File: tb/tb_colisao_bola.sv
// -----------------------------------------------------------------------------
// tb_colisao_bola
// Self-checking bench for colisao_bola (default CARENCIA = 4). Expected hit and
// count values come from a geometric reference model plus a cooldown model and
// are queued when a request is driven, then popped when the result is due.
// -----------------------------------------------------------------------------
module tb_colisao_bola;

   localparam int CAR = 4;

   typedef struct {
      logic        hit;
      int unsigned count;
   } exp_t;

   logic CLOCK_50 = 1'b0;
   logic reset;

   colisao_bola_if bus ();

   colisao_bola #(.CARENCIA(CAR)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus.slave)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int          checks = 0;
   int          fails  = 0;
   exp_t        sb[$];
   int unsigned m_cd   = 0;
   int unsigned m_cnt  = 0;

   function automatic logic geo_hit(int bx, int by, int br, int ax, int ay, int ar, logic at);
      longint dx = longint'(bx) - longint'(ax);
      longint dy = longint'(by) - longint'(ay);
      longint r  = longint'(br) + longint'(ar);
      return (at === 1'b1) && (dx * dx + dy * dy <= r * r);
   endfunction

   task automatic drive_geom(int bx, int by, int br, int ax, int ay, int ar, logic at);
      bus.bola_x     = 10'(bx);
      bus.bola_y     = 10'(by);
      bus.bola_raio  = 10'(br);
      bus.alvo_x     = 10'(ax);
      bus.alvo_y     = 10'(ay);
      bus.alvo_raio  = 10'(ar);
      bus.alvo_ativo = at;
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset        = 1'b0;
      bus.amostrar = 1'b0;
      bus.pausa    = 1'b0;
      @(negedge CLOCK_50);
      reset = 1'b1;
      m_cd  = 0;
      m_cnt = 0;
      sb.delete();
   endtask

   // One accepted evaluation: drives the request, queues the model result and
   // checks busy/hit timing. Optional disturbances while the request is in
   // flight: extra amostrar pulses, pausa, and scrambled geometry.
   task automatic run_eval(string name, int bx, int by, int br, int ax, int ay, int ar,
                           logic at, int gap, bit spurious, bit pause_mid, bit scramble);
      exp_t e;
      logic raw;
      @(negedge CLOCK_50);
      drive_geom(bx, by, br, ax, ay, ar, at);
      bus.pausa    = 1'b0;
      bus.amostrar = 1'b1;
      raw = geo_hit(bx, by, br, ax, ay, ar, at);
      e.hit = 1'b0;
      if (m_cd == 0 && raw) begin
         e.hit = 1'b1;
         m_cd  = CAR;
      end else if (m_cd > 0) begin
         m_cd--;
      end
      if (e.hit && m_cnt < 255) m_cnt++;
      e.count = m_cnt;
      sb.push_back(e);

      for (int k = 0; k < 3; k++) begin
         @(negedge CLOCK_50);
         if (k == 0) begin
            bus.amostrar = spurious;
            if (pause_mid) bus.pausa = 1'b1;
            if (scramble) drive_geom(0, 0, 0, 1023, 1023, 0, ~at);
         end
         checks++;
         if (bus.ocupado !== 1'b1) begin
            fails++;
            $display("FAIL %s busy@N+%0d: ocupado=%b expected 1", name, k, bus.ocupado);
         end
         checks++;
         if (bus.atingiu !== 1'b0) begin
            fails++;
            $display("FAIL %s early_hit@N+%0d: atingiu=%b expected 0", name, k, bus.atingiu);
         end
      end

      @(negedge CLOCK_50);   // after edge N+3
      bus.amostrar = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         fails++;
         $display("FAIL %s scoreboard: queue empty when result due", name);
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.atingiu !== e.hit) begin
            fails++;
            $display("FAIL %s hit: atingiu=%b expected %b", name, bus.atingiu, e.hit);
         end
         checks++;
         if (bus.contagem_acertos !== 8'(e.count)) begin
            fails++;
            $display("FAIL %s count: contagem_acertos=%0d expected %0d", name, bus.contagem_acertos, e.count);
         end
      end
      checks++;
      if (bus.ocupado !== 1'b0) begin
         fails++;
         $display("FAIL %s idle@N+3: ocupado=%b expected 0", name, bus.ocupado);
      end

      @(negedge CLOCK_50);   // after edge N+4
      bus.pausa = 1'b0;
      checks++;
      if (bus.atingiu !== 1'b0 || bus.ocupado !== 1'b0) begin
         fails++;
         $display("FAIL %s after@N+4: atingiu=%b ocupado=%b expected 0 0", name, bus.atingiu, bus.ocupado);
      end
      repeat (gap) @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      bus.pausa    = 1'b0;
      bus.amostrar = 1'b1;   // reset must win over a coincident request
      drive_geom(300, 300, 50, 300, 360, 10, 1'b1);
      repeat (2) @(negedge CLOCK_50);
      checks++;
      if (bus.atingiu !== 1'b0) begin
         fails++;
         $display("FAIL reset atingiu: got %b expected 0", bus.atingiu);
      end
      checks++;
      if (bus.ocupado !== 1'b0) begin
         fails++;
         $display("FAIL reset ocupado: got %b expected 0", bus.ocupado);
      end
      checks++;
      if (bus.contagem_acertos !== 8'd0) begin
         fails++;
         $display("FAIL reset count: got %0d expected 0", bus.contagem_acertos);
      end
      bus.amostrar = 1'b0;
      reset = 1'b1;
      m_cd  = 0;
      m_cnt = 0;
   endtask

   task automatic test_basic();
      do_reset();
      run_eval("basic_hit", 300, 300, 50, 300, 360, 10, 1'b1, 2, 0, 0, 0);
      do_reset();
      run_eval("basic_miss", 300, 300, 50, 300, 361, 10, 1'b1, 2, 0, 0, 0);
   endtask

   task automatic test_boundaries();
      do_reset();
      run_eval("tangent", 0, 0, 5, 3, 4, 0, 1'b1, 1, 0, 0, 0);
      do_reset();
      run_eval("zero_radii_same_centre", 512, 77, 0, 512, 77, 0, 1'b1, 1, 0, 0, 0);
      do_reset();
      run_eval("max_extent_hit", 0, 0, 1023, 1023, 1023, 1023, 1'b1, 1, 0, 0, 0);
      do_reset();
      run_eval("max_extent_miss", 0, 0, 0, 1023, 1023, 0, 1'b1, 1, 0, 0, 0);
      do_reset();
      run_eval("inactive_target", 300, 300, 50, 300, 300, 10, 1'b0, 1, 0, 0, 0);
   endtask

   task automatic test_pause();
      do_reset();
      @(negedge CLOCK_50);
      drive_geom(300, 300, 50, 300, 300, 10, 1'b1);
      bus.pausa    = 1'b1;
      bus.amostrar = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLOCK_50);
         if (k == 1) bus.amostrar = 1'b0;
         checks++;
         if (bus.ocupado !== 1'b0 || bus.atingiu !== 1'b0) begin
            fails++;
            $display("FAIL paused_request@%0d: ocupado=%b atingiu=%b expected 0 0", k, bus.ocupado, bus.atingiu);
         end
      end
      bus.pausa = 1'b0;
      checks++;
      if (bus.contagem_acertos !== 8'd0) begin
         fails++;
         $display("FAIL paused_count: got %0d expected 0", bus.contagem_acertos);
      end
      // pausa rising mid-flight does not cancel the evaluation
      run_eval("pause_mid_flight", 300, 300, 50, 300, 300, 10, 1'b1, 1, 0, 1, 0);
   endtask

   task automatic test_cooldown();
      do_reset();
      for (int i = 1; i <= 8; i++)
         run_eval($sformatf("cooldown_eval%0d", i), 400, 200, 30, 410, 205, 20, 1'b1, 4, 0, 0, 0);
      checks++;
      if (bus.contagem_acertos !== 8'd2) begin
         fails++;
         $display("FAIL cooldown_total: got %0d expected 2", bus.contagem_acertos);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // amostrar held through busy cycles and the return edge is ignored
      run_eval("busy_ignored", 100, 100, 20, 110, 100, 5, 1'b1, 0, 1, 0, 0);
      // geometry changes after capture do not affect the result
      run_eval("scrambled_inputs", 100, 100, 20, 110, 100, 5, 1'b1, 0, 0, 0, 1);
      run_eval("back_to_back_miss", 0, 0, 1, 600, 600, 1, 1'b1, 0, 0, 0, 0);
   endtask

   task automatic test_abort();
      do_reset();
      @(negedge CLOCK_50);
      drive_geom(300, 300, 50, 300, 360, 10, 1'b1);
      bus.amostrar = 1'b1;
      @(negedge CLOCK_50);   // edge N: DIF
      bus.amostrar = 1'b0;
      @(negedge CLOCK_50);   // edge N+1: QUAD
      reset = 1'b0;
      @(negedge CLOCK_50);   // edge N+2 sees reset
      reset = 1'b1;
      checks++;
      if (bus.ocupado !== 1'b0) begin
         fails++;
         $display("FAIL abort ocupado: got %b expected 0", bus.ocupado);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLOCK_50);
         checks++;
         if (bus.atingiu !== 1'b0 || bus.ocupado !== 1'b0) begin
            fails++;
            $display("FAIL abort quiet@%0d: atingiu=%b ocupado=%b expected 0 0", k, bus.atingiu, bus.ocupado);
         end
      end
      checks++;
      if (bus.contagem_acertos !== 8'd0) begin
         fails++;
         $display("FAIL abort count: got %0d expected 0", bus.contagem_acertos);
      end
      m_cd  = 0;
      m_cnt = 0;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 1285; i++)
         run_eval("saturate", 50, 50, 10, 55, 50, 10, 1'b1, 0, 0, 0, 0);
      checks++;
      if (bus.contagem_acertos !== 8'd255) begin
         fails++;
         $display("FAIL saturation: got %0d expected 255", bus.contagem_acertos);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_pause();
      test_cooldown();
      test_back_to_back();
      test_abort();
      test_saturation();
      if (sb.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
